// File: rtl/fifo_rd_pack_pkg.sv
// Shared types and width helpers for the FIFO read-side word packer.
// No logic of its own; the state encoding and width helpers are used by every file of the block.
// Widths derive from RATIO per instance through the helper functions below.
package fifo_rd_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Lane index width, IDX_W = $clog2(RATIO); kept at least 1 bit so degenerate ratios still elaborate.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Valid-lane count width, CNT_W = $clog2(RATIO+1); must represent the value RATIO itself.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_pack_if.sv
// FIFO read port plus packed-word stream, bundled for the packer.
// Pure wiring, zero latency.
// master = packer side (drives rinc and the stream), slave = FIFO/downstream side.
interface fifo_rd_pack_if
  import fifo_rd_pack_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
);

  localparam int CNT_W = cnt_width(RATIO);

  logic                   rempty;
  logic [DSIZE-1:0]       rdata;
  logic                   rinc;
  logic                   flush;
  logic [DSIZE*RATIO-1:0] out_data;
  logic [CNT_W-1:0]       out_cnt;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  rempty, rdata, flush, out_ready,
    output rinc, out_data, out_cnt, out_valid
  );

  modport slave (
    output rempty, rdata, flush, out_ready,
    input  rinc, out_data, out_cnt, out_valid
  );

endinterface

// File: rtl/fifo_rd_pack_tmo.sv
// Idle timer for a partially filled packed word; raises hit when the word has waited tmo_cycles.
// hit is combinational from the registered count, so it acts in the same cycle as a flush would.
// Counts only while filling with lanes pending and no pop; tmo_cycles=0 disables it.
module fifo_rd_pack_tmo
  import fifo_rd_pack_pkg::*;
#(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             filling,
  input  logic             pending,
  input  logic             pop,
  input  logic             leave,
  input  logic [TMO_W-1:0] tmo_cycles,
  output logic             hit
);

  logic [TMO_W-1:0] idle_cnt;

  // Count idle cycles of a pending partial word; any pop or departure from FILL restarts it.
  always_ff @(posedge clk) begin
    if (rst || !filling || pop || leave) begin
      idle_cnt <= '0;
    end else if (pending) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign hit = filling && pending && (tmo_cycles != '0) && (idle_cnt == tmo_cycles);

endmodule

// File: rtl/fifo_rd_pack.sv
// Pops DSIZE words from a FWFT FIFO and packs RATIO of them (lane 0 oldest) into one stream word.
// out_valid rises one cycle after the final pop or flush edge; rinc is combinational.
// Holds out_data/out_cnt while out_ready=0; a handoff may pop the next word's lane 0 in the same cycle.
// Optional idle timeout enabled by defining FIFO_RD_PACK_TMO_EN (adds the tmo_cycles port).
module fifo_rd_pack
  import fifo_rd_pack_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int RATIO = 4,
  parameter int TMO_W = 8
) (
  input  logic             rclk,
  input  logic             rrst,
`ifdef FIFO_RD_PACK_TMO_EN
  input  logic [TMO_W-1:0] tmo_cycles,
`endif
  fifo_rd_pack_if.master   rd
);

  localparam int IDX_W = idx_width(RATIO);
  localparam int CNT_W = cnt_width(RATIO);
  localparam int WIDTH = DSIZE * RATIO;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
  // An illegal configuration leaves the block inert instead of popping words it cannot pack.
  localparam bit CFG_OK = (RATIO >= 2) && (TMO_W >= 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] lanes;
  logic [CNT_W-1:0] cnt;
  logic             valid;

  logic pop;
  logic flush_req;
  logic tmo_hit;
  logic go_hold;

  // Pop whenever there is room: always while filling, and in HOLD only on the handoff cycle.
  assign pop = CFG_OK && !rrst && !rd.rempty &&
               ((state == FILL) || ((state == HOLD) && rd.out_ready));

  assign flush_req = rd.flush || tmo_hit;

  // Leave FILL when the last lane is written, or on a flush that has at least one word to send.
  assign go_hold = (state == FILL) &&
                   ((pop && (idx == LAST_IDX)) || (flush_req && ((idx != '0) || pop)));

  assign rd.rinc      = pop;
  assign rd.out_data  = lanes;
  assign rd.out_cnt   = cnt;
  assign rd.out_valid = valid;

`ifdef FIFO_RD_PACK_TMO_EN
  fifo_rd_pack_tmo #(
    .TMO_W(TMO_W)
  ) u_tmo (
    .clk       (rclk),
    .rst       (rrst),
    .filling   (state == FILL),
    .pending   (idx != '0),
    .pop       (pop),
    .leave     (go_hold),
    .tmo_cycles(tmo_cycles),
    .hit       (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // Packing FSM: FILL gathers lanes, HOLD presents the word until the downstream takes it.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= FILL;
      idx   <= '0;
      lanes <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (state == FILL) begin
      if (pop) begin
        lanes[idx*DSIZE +: DSIZE] <= rd.rdata;
      end
      if (go_hold) begin
        state <= HOLD;
        valid <= 1'b1;
        cnt   <= CNT_W'(idx) + CNT_W'(pop);
        idx   <= '0;
      end else if (pop) begin
        idx <= idx + 1'b1;
      end
    end else if (rd.out_ready) begin
      // Handoff: unused lanes of the next word must read as zero, so clear them all first.
      state <= FILL;
      valid <= 1'b0;
      cnt   <= '0;
      lanes <= '0;
      idx   <= '0;
      if (pop) begin
        lanes[DSIZE-1:0] <= rd.rdata;
        idx              <= IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Self-checking bench for fifo_rd_pack: reset, vector table, hand sequences, randomized run vs model.
// Inputs change just after the falling edge; outputs are sampled 1 ns later, well before the rising edge.
// Timeout sequences compile in only when FIFO_RD_PACK_TMO_EN is defined.
module tb_fifo_rd_pack;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;
  localparam int TMO_W = 8;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
`ifdef FIFO_RD_PACK_TMO_EN
  logic [TMO_W-1:0] tmo = '0;
`endif

  fifo_rd_pack_if #(.DSIZE(DSIZE), .RATIO(RATIO)) rd ();

  fifo_rd_pack #(
    .DSIZE(DSIZE),
    .RATIO(RATIO),
    .TMO_W(TMO_W)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
`ifdef FIFO_RD_PACK_TMO_EN
    .tmo_cycles(tmo),
`endif
    .rd        (rd)
  );

  always #5 rclk = ~rclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: a queue of pending words and a held packed word ----------------
  bit         m_hold = 1'b0;
  logic [7:0] m_part[$];
  logic [31:0] m_word = '0;
  int         m_cnt  = 0;
  int         m_idle = 0;
  bit         m_zero = 1'b0;

  function automatic bit m_rinc();
    return !rrst && !rd.rempty && (!m_hold || rd.out_ready);
  endfunction

  function automatic bit m_hit();
`ifdef FIFO_RD_PACK_TMO_EN
    return !m_hold && (m_part.size() > 0) && (tmo != 0) && (m_idle == int'(tmo));
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_in(input bit rst, input bit e, input logic [7:0] d, input bit f, input bit r);
    rrst         = rst;
    rd.rempty    = e;
    rd.rdata     = d;
    rd.flush     = f;
    rd.out_ready = r;
    #1;
  endtask

  // Advance one clock and move the model by the rules: collect words, emit on full/flush/timeout.
  task automatic tick();
    bit p, h, f, r, rst;
    logic [7:0] d;
    p = m_rinc(); h = m_hit(); f = rd.flush; r = rd.out_ready; rst = rrst; d = rd.rdata;
    @(posedge rclk);
    if (rst) begin
      m_hold = 1'b0; m_part.delete(); m_idle = 0; m_zero = 1'b1;
    end else if (m_hold) begin
      if (r) begin
        m_hold = 1'b0; m_part.delete(); m_idle = 0; m_zero = 1'b0;
        if (p) m_part.push_back(d);
      end
    end else begin
      if (p) m_part.push_back(d);
      if (m_part.size() == RATIO || ((f || h) && m_part.size() > 0)) begin
        m_word = '0;
        foreach (m_part[i]) m_word[i*8 +: 8] = m_part[i];
        m_cnt  = m_part.size();
        m_hold = 1'b1; m_part.delete(); m_idle = 0; m_zero = 1'b0;
      end else if (p) begin
        m_idle = 0; m_zero = 1'b0;
      end else if (m_part.size() > 0) begin
        m_idle = (m_idle + 1) % (1 << TMO_W);
      end
    end
    @(negedge rclk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rinc"}, 32'(rd.rinc), 32'(m_rinc()));
    check({tag, "_valid"}, 32'(rd.out_valid), 32'(m_hold));
    if (m_hold) begin
      check({tag, "_data"}, rd.out_data, m_word);
      check({tag, "_cnt"}, 32'(rd.out_cnt), 32'(m_cnt));
    end else if (m_zero) begin
      check({tag, "_zdata"}, rd.out_data, 32'h0);
      check({tag, "_zcnt"}, 32'(rd.out_cnt), 32'h0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst, empty;
    logic [7:0]  d;
    bit          fl, rdy;
    bit          x_rinc, x_valid, chk;
    logic [31:0] x_data;
    logic [2:0]  x_cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    automatic int rise, seen;
    automatic logic [7:0] head;

    tbl[0]  = '{0, 0, 8'h11, 0, 1, 1, 0, 1, 32'h0,        3'd0};
    tbl[1]  = '{0, 0, 8'h22, 0, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[2]  = '{0, 0, 8'h33, 0, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[3]  = '{0, 0, 8'h44, 0, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[4]  = '{0, 1, 8'h00, 0, 1, 0, 1, 1, 32'h44332211, 3'd4};
    tbl[5]  = '{0, 1, 8'hA1, 0, 1, 0, 0, 0, 32'h0,        3'd0};
    tbl[6]  = '{0, 0, 8'hA1, 0, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[7]  = '{0, 0, 8'hB2, 0, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[8]  = '{0, 1, 8'h00, 1, 1, 0, 0, 0, 32'h0,        3'd0};
    tbl[9]  = '{0, 1, 8'h00, 0, 0, 0, 1, 1, 32'h0000B2A1, 3'd2};
    tbl[10] = '{0, 1, 8'h00, 0, 1, 0, 1, 1, 32'h0000B2A1, 3'd2};
    tbl[11] = '{0, 1, 8'h00, 1, 1, 0, 0, 0, 32'h0,        3'd0};
    tbl[12] = '{0, 1, 8'h00, 0, 1, 0, 0, 0, 32'h0,        3'd0};
    tbl[13] = '{0, 0, 8'hA1, 0, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[14] = '{0, 0, 8'hB2, 0, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[15] = '{0, 0, 8'hC3, 1, 1, 1, 0, 0, 32'h0,        3'd0};
    tbl[16] = '{0, 1, 8'h00, 0, 1, 0, 1, 1, 32'h00C3B2A1, 3'd3};
    tbl[17] = '{0, 1, 8'h00, 0, 1, 0, 0, 0, 32'h0,        3'd0};

    // Reset held 3 cycles with data available: never pops, outputs cleared.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 8'h11, 0, 1);
      check($sformatf("rst%0d_rinc", i), 32'(rd.rinc), 32'h0);
      if (i > 0) begin
        check($sformatf("rst%0d_valid", i), 32'(rd.out_valid), 32'h0);
        check($sformatf("rst%0d_data", i), rd.out_data, 32'h0);
        check($sformatf("rst%0d_cnt", i), 32'(rd.out_cnt), 32'h0);
      end
      tick();
    end

    // Full pack, flush, ignored flush, flush with a same-cycle pop.
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].rst, tbl[i].empty, tbl[i].d, tbl[i].fl, tbl[i].rdy);
      check($sformatf("tbl%0d_rinc", i), 32'(rd.rinc), 32'(tbl[i].x_rinc));
      check($sformatf("tbl%0d_valid", i), 32'(rd.out_valid), 32'(tbl[i].x_valid));
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_data", i), rd.out_data, tbl[i].x_data);
        check($sformatf("tbl%0d_cnt", i), 32'(rd.out_cnt), 32'(tbl[i].x_cnt));
      end
      tick();
    end

    // Backpressure: 10 stalled cycles (flush ignored in HOLD), then handoff with a same-cycle pop.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 8'hD1 + 8'(i), 0, 0);
      check("bp_fill_rinc", 32'(rd.rinc), 32'h1);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 8'h55, (i == 3), 0);
      check("bp_hold_rinc", 32'(rd.rinc), 32'h0);
      check("bp_hold_data", rd.out_data, 32'hD4D3D2D1);
      check("bp_hold_cnt", 32'(rd.out_cnt), 32'h4);
      tick();
    end
    set_in(0, 0, 8'h55, 0, 1);
    check("bp_handoff_rinc", 32'(rd.rinc), 32'h1);
    check("bp_handoff_valid", 32'(rd.out_valid), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 8'h66 + 8'(i * 'h11), 0, 1);
      check("bp_next_rinc", 32'(rd.rinc), 32'h1);
      tick();
    end
    set_in(0, 1, 8'h00, 0, 1);
    check("bp_next_data", rd.out_data, 32'h88776655);
    tick();

    // Reset mid-word discards the partial data.
    set_in(0, 0, 8'hE1, 0, 1); tick();
    set_in(0, 0, 8'hE2, 0, 1); tick();
    set_in(1, 0, 8'hE3, 0, 1); tick();
    set_in(0, 1, 8'h00, 0, 1);
    check("midrst_data", rd.out_data, 32'h0);
    check("midrst_valid", 32'(rd.out_valid), 32'h0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 8'(i), 0, 1); tick();
    end
    set_in(0, 1, 8'h00, 1, 1);
    check("midrst_word", rd.out_data, 32'h04030201);
    tick();

`ifdef FIFO_RD_PACK_TMO_EN
    // Timeout 5: lone word goes out 6 cycles after its pop.
    tmo = 8'd5;
    set_in(0, 0, 8'h7E, 0, 1); tick();
    rise = -1;
    for (int k = 0; k <= 20 && rise < 0; k++) begin
      set_in(0, 1, 8'h00, 0, 0);
      if (rd.out_valid) rise = k;
      tick();
    end
    check("tmo_rise", 32'(rise), 32'd6);
    set_in(0, 1, 8'h00, 0, 1);
    check("tmo_data", rd.out_data, 32'h0000007E);
    check("tmo_cnt", 32'(rd.out_cnt), 32'h1);
    tick();
    // Timeout 0: disabled.
    tmo = 8'd0;
    set_in(0, 0, 8'h7E, 0, 1); tick();
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      set_in(0, 1, 8'h00, 0, 1);
      if (rd.out_valid) seen++;
      tick();
    end
    check("tmo0_never", 32'(seen), 32'h0);
    set_in(0, 1, 8'h00, 1, 1); tick();
    set_in(0, 1, 8'h00, 0, 1);
    check("tmo0_flush_cnt", 32'(rd.out_cnt), 32'h1);
    tick();
`endif

    // Randomized run against the model.
    head = 8'($urandom);
    for (int c = 0; c < 800; c++) begin
      automatic bit p;
`ifdef FIFO_RD_PACK_TMO_EN
      if (c % 200 == 0) tmo = 8'($urandom_range(0, 6));
`endif
      set_in($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35, head,
             $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 60);
      check_model($sformatf("rnd%0d", c));
      p = m_rinc();
      tick();
      if (p) head = 8'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

endmodule
